// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle CHUNK-per-clock two's-complement adder/subtractor
// Optional build macro SATURATE_EN clamps overflowed results to the signed limit.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_cout;
    logic             r_v;
    logic             r_z;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic             w_last;
    logic             w_v;
    logic [WIDTH-1:0] w_s_merged;
    logic [WIDTH-1:0] w_s_final;

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last    = (r_idx == IW'(NCHUNK - 1));
    // On the last chunk the top operand bits are the MSB: carry-in to MSB is a^b^sum there.
    assign w_v       = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];

    always_comb begin
        w_s_merged = r_s;
        w_s_merged[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

`ifdef SATURATE_EN
    always_comb begin
        w_s_final = w_s_merged;
        if (w_v) begin
            w_s_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_s_final = w_s_merged;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_carry <= Cin ^ sub;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_carry <= w_sum[CHUNK];
                    if (w_last) begin
                        r_s    <= w_s_final;
                        r_cout <= w_sum[CHUNK];
                        r_v    <= w_v;
                        r_z    <= (w_s_final == '0);
                    end else begin
                        r_s   <= w_s_merged;
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign S    = r_s;
    assign Cout = r_cout;
    assign V    = r_v;
    assign Z    = r_z;
endmodule
